arb_egress_fifo: RTL

Synchronous FIFO that sits directly downstream of arbiter4_pipeline. It absorbs the arbiter's single output stream so downstream back-pressure does not stall arbitration immediately. Both sides use valid/ready handshakes, and the upstream side connects port-for-port to the arbiter's valid_out/data_out/ready_in.

---
 rtl/arb_egress_fifo.sv | 72 +++++++
 1 files changed

// File: rtl/arb_egress_fifo.sv
// arb_egress_fifo: first-word fall-through FIFO that buffers the arbiter's output
// stream. Status flags decode from the registered count only, so ready_out has
// no combinational dependence on ready_in.
module arb_egress_fifo #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ready_out,
    output logic                       valid_out,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       ready_in,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Handshake and status decode, all from registered state
    always_comb begin
        ready_out   = (count != CW'(DEPTH));
        valid_out   = (count != '0);
        almost_full = (count >= CW'(AF_LEVEL));
        data_out    = mem[rd_ptr];
        push        = valid_in & ready_out;
        pop         = valid_out & ready_in;
    end

    // Storage write; contents cleared on reset so the head word is never unknown
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointer and occupancy tracking; full/empty come from count, not pointer equality
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
